pipe_adder: RTL and testbench
=============================

# pipe_adder

Parametrised, pipelined binary adder/subtractor with a valid/ready handshake. It generalises the single-bit registered half adder to WIDTH bits. The carry ripples through CHUNK-bit slices, one register stage per slice, so timing is bounded for wide operands. It is the arithmetic leaf used by the datapath blocks under formal and simulation verification.

## Interface
Parameters:
- WIDTH, 8: operand and result width; must be ≥1.
- CHUNK, 4: bits added per pipeline stage; WIDTH % CHUNK == 0, elaboration error otherwise.
- STAGES, WIDTH/CHUNK: derived localparam, not overridable; equals the latency.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operands present.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- sub  in  1  0 = a+b, 1 = a−b.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result modulo 2^WIDTH.
- cout  out  1  carry out; for subtract this is NOT borrow, i.e. 1 when a ≥ b unsigned.
- ovf  out  1  signed overflow.

## Operation
- Subtract is computed as a + ~b + 1. The +1 is the carry-in of slice 0.
- Stage k (k = 0..STAGES−1):
  - adds slice k of a and of the conditioned b, plus the carry registered by stage k−1;
  - registers its partial sum, its carry, and a valid bit;
  - forwards the not-yet-consumed upper operand slices and the sub bit.
- Last stage outputs:
  - sum is the concatenation of all registered slices;
  - cout is the final carry;
  - ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), where b' is the conditioned b. Operand MSBs are carried down the pipe for this.
- Flow control uses a global enable: adv = !out_valid || out_ready.
  - All stages shift only when adv is high.
  - in_ready = adv && rstn.
  - Bubbles are not collapsed; this is intentional and keeps ready purely combinational on one signal.
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- Results leave in acceptance order. No drop, no duplication.
- While rstn is low:
  - all valid bits, slice registers, carries, sum, cout and ovf are 0;
  - in_ready is 0.
- Reset asserted mid-operation discards every in-flight operation immediately (asynchronously). No stale result appears after release.

## Timing
- Latency: an operation accepted at edge t yields out_valid = 1 with its result after edge t+STAGES−1, i.e. visible in the cycle after the STAGES-th edge, when no stall occurs.
- Throughput: one operation per cycle while out_ready is held high.
- Stall: out_valid && !out_ready freezes every stage. sum, cout and ovf are held stable and in_ready is 0 in the same cycle (combinational).
- Simultaneous output and input transfer in one cycle is legal and sustains full rate.
- in_valid low while adv is high inserts a bubble: that stage's valid bit becomes 0 and its data is don't-care (it is not checked).
- Degenerate configurations:
  - CHUNK == WIDTH gives STAGES = 1, a single registered adder;
  - CHUNK == 1 gives STAGES = WIDTH, a bit-serial carry pipeline.
- Reset release: first acceptance is possible at the first rising edge with rstn high.

## Structure
- Package pipe_adder_pkg holds:
  - the slice_t/stage register struct type: partial sum, carry, valid, pending operand slices, sub, operand MSBs;
  - the width-check function used by the elaboration assertion.
- Sub-module pipe_adder_stage implements one CHUNK-bit slice adder plus its register. The top instantiates STAGES copies in a generate loop and owns the adv / in_ready logic.

## Test plan
All scenarios use WIDTH=8, CHUNK=4 (latency 2) unless stated.
- Carry crossing a slice boundary: add 0x0F + 0x01 → sum 0x10, cout 0, ovf 0, exactly 2 cycles after acceptance.
- Signed overflow, add: 0x7F + 0x01 → 0x80, ovf 1, cout 0. Unsigned wrap: 0xFF + 0x01 → 0x00, cout 1, ovf 0.
- Subtract:
  - 0x00 − 0x01 → 0xFF, cout 0, ovf 0;
  - 0x80 − 0x01 → 0x7F, cout 1, ovf 1;
  - 0x05 − 0x05 → 0x00, cout 1.
- Stall:
  - stream 4 back-to-back operations;
  - hold out_ready low for 3 cycles from the first out_valid;
  - required: in_ready low throughout the stall, outputs stable, all 4 results in order with none lost or duplicated.
- Reset mid-flight: drop rstn with 2 operations in flight → out_valid, sum, cout, ovf and in_ready all 0 asynchronously. After release, no result appears until new input is accepted.
- Parameter sweep with random operands checked against a reference a±b:
  - WIDTH=16, CHUNK=16: latency 1;
  - WIDTH=16, CHUNK=1: latency 16;
  - full-rate streaming, 1000 operations each.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// Shared types and configuration checks for the sliced pipelined adder.
package pipe_adder_pkg;

   typedef struct packed {
      logic valid;
      logic carry;
      logic sub;
      logic a_msb;
      logic b_msb;
   } slice_t;

   function automatic bit width_ok(input int w, input int c);
      if (w < 1 || c < 1) return 1'b0;
      return (w % c) == 0;
   endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// One CHUNK-bit slice of the carry pipeline with its stage register.
module pipe_adder_stage
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4,
   parameter int K     = 0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             adv_i,
   input  slice_t           ctl_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] sum_i,
   output slice_t           ctl_o,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic [WIDTH-1:0] sum_o
);

   localparam int LO = K * CHUNK;

   logic [CHUNK-1:0] sa, sb, ps;
   logic             co;
   slice_t           ctl_d, ctl_q;
   logic [WIDTH-1:0] a_d, a_q, b_d, b_q, sum_d, sum_q;

   // b is conditioned per slice; consumed operand slices are dropped.
   always_comb begin
      sa = a_i[LO +: CHUNK];
      sb = b_i[LO +: CHUNK] ^ {CHUNK{ctl_i.sub}};
      {co, ps} = {1'b0, sa} + {1'b0, sb} + {{CHUNK{1'b0}}, ctl_i.carry};
      ctl_d = ctl_i;
      ctl_d.carry = co;
      a_d = a_i;
      a_d[LO +: CHUNK] = '0;
      b_d = b_i;
      b_d[LO +: CHUNK] = '0;
      sum_d = sum_i;
      sum_d[LO +: CHUNK] = ps;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ctl_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
         sum_q <= '0;
      end else if (adv_i) begin
         ctl_q <= ctl_d;
         a_q   <= a_d;
         b_q   <= b_d;
         sum_q <= sum_d;
      end
   end

   assign ctl_o = ctl_q;
   assign a_o   = a_q;
   assign b_o   = b_q;
   assign sum_o = sum_q;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor, one register stage per CHUNK slice.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES =
      (CHUNK > 0 && WIDTH >= CHUNK) ? WIDTH / CHUNK : 1;

   if (!width_ok(WIDTH, CHUNK)) begin : g_bad_cfg
      $error("pipe_adder: WIDTH must be >=1 and a multiple of CHUNK");
   end

   slice_t           ctl_s [STAGES+1];
   logic [WIDTH-1:0] a_s   [STAGES+1];
   logic [WIDTH-1:0] b_s   [STAGES+1];
   logic [WIDTH-1:0] sum_s [STAGES+1];
   logic             adv;
   logic             unused_ok;

   // One global enable: bubbles stay in place, ready depends on one signal.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv && rstn;

   assign ctl_s[0] = '{valid: in_valid,
                       carry: sub,
                       sub:   sub,
                       a_msb: a[WIDTH-1],
                       b_msb: b[WIDTH-1] ^ sub};
   assign a_s[0]   = a;
   assign b_s[0]   = b;
   assign sum_s[0] = '0;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      pipe_adder_stage #(
         .WIDTH(WIDTH),
         .CHUNK(CHUNK),
         .K    (k)
      ) u_stage (
         .clk  (clk),
         .rstn (rstn),
         .adv_i(adv),
         .ctl_i(ctl_s[k]),
         .a_i  (a_s[k]),
         .b_i  (b_s[k]),
         .sum_i(sum_s[k]),
         .ctl_o(ctl_s[k+1]),
         .a_o  (a_s[k+1]),
         .b_o  (b_s[k+1]),
         .sum_o(sum_s[k+1])
      );
   end

   assign out_valid = ctl_s[STAGES].valid;
   assign sum       = sum_s[STAGES];
   assign cout      = ctl_s[STAGES].carry;
   assign ovf       = (ctl_s[STAGES].a_msb == ctl_s[STAGES].b_msb) &&
                      (sum_s[STAGES][WIDTH-1] != ctl_s[STAGES].a_msb);

   assign unused_ok = ^{a_s[STAGES], b_s[STAGES], ctl_s[STAGES].sub};

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench: directed vectors, stall/reset sequences, random sweeps.
module tb_pipe_adder;

   typedef struct packed {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
      logic [7:0] s;
      logic       c;
      logic       o;
      string      nm;
   } vec_t;

   logic clk = 1'b0;
   logic rstn = 1'b1;
   always #5 clk = ~clk;

   logic       in_valid8, in_ready8, sub8, out_valid8, out_ready8;
   logic       cout8, ovf8;
   logic [7:0] a8, b8, sum8;

   logic        iv16, sub16, ordy16;
   logic [15:0] a16, b16;
   logic        ir_x, ov_x, co_x, of_x;
   logic [15:0] sum_x;
   logic        ir_y, ov_y, co_y, of_y;
   logic [15:0] sum_y;

   int n_cmp = 0;
   int n_bad = 0;
   vec_t vt[8];

   pipe_adder #(.WIDTH(8), .CHUNK(4)) u_dut8 (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .sub(sub8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .sum(sum8), .cout(cout8), .ovf(ovf8)
   );

   pipe_adder #(.WIDTH(16), .CHUNK(16)) u_dutx (
      .clk(clk), .rstn(rstn),
      .in_valid(iv16), .in_ready(ir_x),
      .a(a16), .b(b16), .sub(sub16),
      .out_valid(ov_x), .out_ready(ordy16),
      .sum(sum_x), .cout(co_x), .ovf(of_x)
   );

   pipe_adder #(.WIDTH(16), .CHUNK(1)) u_duty (
      .clk(clk), .rstn(rstn),
      .in_valid(iv16), .in_ready(ir_y),
      .a(a16), .b(b16), .sub(sub16),
      .out_valid(ov_y), .out_ready(ordy16),
      .sum(sum_y), .cout(co_y), .ovf(of_y)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: integer arithmetic on the operand values.
   function automatic res_t ref_calc(input int w, input logic [31:0] a,
                                     input logic [31:0] b, input logic sub);
      longint m = longint'(1) << w;
      longint h = m >> 1;
      longint la = longint'(a);
      longint lb = longint'(b);
      longint sa = (la >= h) ? la - m : la;
      longint sb = (lb >= h) ? lb - m : lb;
      longint u, s;
      res_t r;
      if (sub) begin
         u = la - lb;
         s = sa - sb;
         r.cout = (la >= lb);
      end else begin
         u = la + lb;
         s = sa + sb;
         r.cout = (u >= m);
      end
      r.sum = 16'(((u % m) + m) % m);
      r.ovf = (s >= h) || (s < -h);
      return r;
   endfunction

   task automatic stream8(input int nops, input int pv, input int pr,
                          input bit stall3);
      res_t q[$];
      res_t r;
      int sent = 0, got = 0, cyc = 0, stall_left = 0;
      bit stall_seen = 0, prev_stall = 0;
      logic [9:0] hold = '0;
      logic [7:0] na = 8'($urandom), nb = 8'($urandom);
      logic ns = 1'($urandom);
      while ((sent < nops || got < nops) && cyc < nops * 20 + 50) begin
         @(negedge clk);
         if (stall3) begin
            if (out_valid8 && !stall_seen) begin
               stall_seen = 1;
               stall_left = 3;
            end
            out_ready8 = (stall_left == 0);
            if (stall_left > 0) stall_left--;
         end else begin
            out_ready8 = ($urandom_range(99) < pr);
         end
         in_valid8 = (sent < nops) && (stall3 || $urandom_range(99) < pv);
         a8 = na;
         b8 = nb;
         sub8 = ns;
         #1;
         if (out_valid8 && !out_ready8) begin
            chk("stall in_ready", 32'(in_ready8), 32'(0));
            if (prev_stall)
               chk("stall hold", 32'({sum8, cout8, ovf8}), 32'(hold));
            hold = {sum8, cout8, ovf8};
            prev_stall = 1;
         end else begin
            prev_stall = 0;
         end
         if (out_valid8 && out_ready8) begin
            if (q.size() == 0) begin
               chk("spurious out", 32'(1), 32'(0));
            end else begin
               r = q.pop_front();
               chk("stream result", 32'({sum8, cout8, ovf8}),
                   32'({r.sum[7:0], r.cout, r.ovf}));
            end
            got++;
         end
         if (in_valid8 && in_ready8) begin
            q.push_back(ref_calc(8, 32'(na), 32'(nb), ns));
            sent++;
            na = 8'($urandom);
            nb = 8'($urandom);
            ns = 1'($urandom);
         end
         cyc++;
      end
      chk("stream count", 32'(got), 32'(nops));
      in_valid8 = 1'b0;
      out_ready8 = 1'b1;
      repeat (4) @(negedge clk);
      #1 chk("stream drained", 32'(out_valid8), 32'(0));
   endtask

   task automatic sweep16(input int n);
      res_t qx[$], qy[$];
      int dx[$], dy[$];
      int sent = 0, gx = 0, gy = 0, cyc = 0, d;
      res_t r;
      while ((gx < n || gy < n) && cyc < n + 200) begin
         @(negedge clk);
         ordy16 = 1'b1;
         iv16 = (sent < n);
         a16 = 16'($urandom);
         b16 = 16'($urandom);
         sub16 = 1'($urandom);
         #1;
         if (ov_x) begin
            if (qx.size() == 0) begin
               chk("x spurious", 32'(1), 32'(0));
            end else begin
               r = qx.pop_front();
               d = dx.pop_front();
               chk("x result", 32'({sum_x, co_x, of_x}),
                   32'({r.sum, r.cout, r.ovf}));
               chk("x latency", 32'(cyc), 32'(d));
            end
            gx++;
         end
         if (ov_y) begin
            if (qy.size() == 0) begin
               chk("y spurious", 32'(1), 32'(0));
            end else begin
               r = qy.pop_front();
               d = dy.pop_front();
               chk("y result", 32'({sum_y, co_y, of_y}),
                   32'({r.sum, r.cout, r.ovf}));
               chk("y latency", 32'(cyc), 32'(d));
            end
            gy++;
         end
         if (iv16) begin
            chk("sweep in_ready", 32'({ir_x, ir_y}), 32'(2'b11));
            if (ir_x && ir_y) begin
               r = ref_calc(16, 32'(a16), 32'(b16), sub16);
               qx.push_back(r);
               dx.push_back(cyc + 1);
               qy.push_back(r);
               dy.push_back(cyc + 16);
               sent++;
            end
         end
         cyc++;
      end
      iv16 = 1'b0;
      chk("x count", 32'(gx), 32'(n));
      chk("y count", 32'(gy), 32'(n));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      vt[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "carry_slice"};
      vt[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_ovf"};
      vt[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_wrap"};
      vt[3] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, "sub_borrow"};
      vt[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_ovf"};
      vt[5] = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, "sub_equal"};
      vt[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "add_negneg"};
      vt[7] = '{8'h12, 8'h34, 1'b1, 8'hDE, 1'b0, 1'b0, "sub_small"};

      in_valid8 = 0; a8 = 0; b8 = 0; sub8 = 0; out_ready8 = 1;
      iv16 = 0; a16 = 0; b16 = 0; sub16 = 0; ordy16 = 1;

      #2 rstn = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset dut8", 32'({out_valid8, in_ready8, cout8, ovf8, sum8}),
          32'(0));
      chk("reset dutx", 32'({ov_x, ir_x, co_x, of_x, sum_x}), 32'(0));
      chk("reset duty", 32'({ov_y, ir_y, co_y, of_y, sum_y}), 32'(0));
      @(negedge clk);
      rstn = 1'b1;
      #1 chk("release in_ready", 32'(in_ready8), 32'(1));

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         a8 = vt[i].a;
         b8 = vt[i].b;
         sub8 = vt[i].sub;
         in_valid8 = 1'b1;
         #1 chk({vt[i].nm, " in_ready"}, 32'(in_ready8), 32'(1));
         @(negedge clk);
         in_valid8 = 1'b0;
         #1 chk({vt[i].nm, " early"}, 32'(out_valid8), 32'(0));
         @(negedge clk);
         #1 chk({vt[i].nm, " result"},
                32'({out_valid8, sum8, cout8, ovf8}),
                32'({1'b1, vt[i].s, vt[i].c, vt[i].o}));
      end

      stream8(4, 100, 100, 1'b1);
      stream8(300, 70, 60, 1'b0);

      @(negedge clk);
      out_ready8 = 1'b0;
      a8 = 8'h90; b8 = 8'h90; sub8 = 1'b0; in_valid8 = 1'b1;
      @(negedge clk);
      a8 = 8'h33; b8 = 8'h11; sub8 = 1'b1;
      @(negedge clk);
      in_valid8 = 1'b0;
      #1 chk("pre-reset out", 32'({out_valid8, sum8, cout8, ovf8}),
             32'({1'b1, 8'h20, 1'b1, 1'b1}));
      #1 rstn = 1'b0;
      #1 chk("async reset", 32'({out_valid8, in_ready8, cout8, ovf8, sum8}),
             32'(0));
      @(negedge clk);
      rstn = 1'b1;
      out_ready8 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1 chk("post-reset idle", 32'(out_valid8), 32'(0));
      end
      @(negedge clk);
      a8 = 8'h3C; b8 = 8'h0A; sub8 = 1'b0; in_valid8 = 1'b1;
      @(negedge clk);
      in_valid8 = 1'b0;
      @(negedge clk);
      #1 chk("post-reset op", 32'({out_valid8, sum8, cout8, ovf8}),
             32'({1'b1, 8'h46, 1'b0, 1'b0}));

      sweep16(1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
